// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous-read memory port between instruction fetch and load/store.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int          BE_W       = DATA_W / 8;
  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] starve_cnt_r;
  logic [3:0] starve_cnt_next_s;
  logic       grant_d_s;
  logic       grant_if_s;

  // Grant decision, suppressed entirely while reset is held
  always_comb begin
    grant_d_s  = 1'b0;
    grant_if_s = 1'b0;
    if (RST) begin
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
    end else if (d_req && !(if_req && (starve_cnt_r == STARVE_MAX))) begin
      grant_d_s = 1'b1;
    end else if (if_req) begin
      grant_if_s = 1'b1;
    end else begin
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
    end
  end

  // Next-state: the granted requester owns the following completion cycle
  always_comb begin
    state_next_s = IDLE;
    if (grant_d_s) begin
      state_next_s = BUSY_D;
    end else if (grant_if_s) begin
      state_next_s = BUSY_IF;
    end else begin
      state_next_s = IDLE;
    end
  end

  // Starvation count: data grants in a row while a fetch is waiting, saturating
  always_comb begin
    starve_cnt_next_s = starve_cnt_r;
    if (!if_req || grant_if_s) begin
      starve_cnt_next_s = 4'd0;
    end else if (grant_d_s && (starve_cnt_r < STARVE_MAX)) begin
      starve_cnt_next_s = starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_next_s = starve_cnt_r;
    end
  end

  // State and starvation counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= IDLE;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r      <= state_next_s;
      starve_cnt_r <= starve_cnt_next_s;
    end
  end

  // Memory port drive for the cycle's grant
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = {BE_W{1'b0}};
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    if (grant_d_s) begin
      mem_en    = 1'b1;
      mem_we    = d_we ? d_be : {BE_W{1'b0}};
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (grant_if_s) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end else begin
      mem_en    = 1'b0;
    end
  end

  // Completion pulses; the read data is forwarded straight from the memory
  always_comb begin
    if_ready = 1'b0;
    d_ready  = 1'b0;
    if_rdata = {DATA_W{1'b0}};
    d_rdata  = {DATA_W{1'b0}};
    if (RST) begin
      if_ready = 1'b0;
      d_ready  = 1'b0;
    end else begin
      case (state_r)
        BUSY_IF: begin
          if_ready = 1'b1;
          if_rdata = mem_rdata;
        end
        BUSY_D: begin
          d_ready = 1'b1;
          d_rdata = mem_rdata;
        end
        default: begin
          if_ready = 1'b0;
          d_ready  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences and
// a randomized run against a request-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int SL = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req, d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ready, d_ready, mem_en;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  logic        ram_loaded = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)  return 32'h00500093;
    if (i == 64) return 32'h00000000;
    return (32'(i) * 32'h01010101) ^ 32'h00000013;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Synchronous-read memory with byte write enables
  always @(posedge CLK) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (mem_en) begin
      mem_rdata          <= ram[mem_addr[9:2]];
      ram[mem_addr[9:2]] <= merge(ram[mem_addr[9:2]], mem_wdata, mem_we);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        ir, dr, we;
    logic [3:0]  be;
    logic [31:0] ia, da, wd;
    logic        een;
    logic [3:0]  ewe;
    logic [31:0] eaddr, ewd;
    logic        eifr, edr;
  } vec_t;

  vec_t vt [7];

  // randomized-run model state
  bit          ip, dp, dwe, pwe, gwe;
  logic [3:0]  dbe;
  logic [31:0] ia, da, dwd, pdata, gdata;
  int          st, g, pg;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    vt[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0,   32'h0,        1'b1, 4'h0, 32'h10,  32'h0,        1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0,  32'h20,  32'h12345678, 1'b1, 4'h0, 32'h20,  32'h12345678, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 1'b1, 4'hF, 32'h0,  32'h300, 32'hCAFEF00D, 1'b1, 4'hF, 32'h300, 32'hCAFEF00D, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 4'h0, 32'h18, 32'h24,  32'h0,        1'b1, 4'h0, 32'h24,  32'h0,        1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b1, 1'b1, 4'h8, 32'h18, 32'h304, 32'hA5A5A5A5, 1'b1, 4'h8, 32'h304, 32'hA5A5A5A5, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b0, 1'b1, 4'hF, 32'h10, 32'h20,  32'h0,        1'b0, 4'h0, 32'h0,   32'h0,        1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b1, 1'b1, 4'h0, 32'h0,  32'h308, 32'hFFFFFFFF, 1'b1, 4'h0, 32'h308, 32'hFFFFFFFF, 1'b0, 1'b1};

    // reset held with both requesters active
    RST = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_be = 4'h0;
    if_addr = 32'h10; d_addr = 32'h200; d_wdata = 32'h0;
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
      chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
      if (i == 4) begin
        chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
      end
      next_cyc();
    end
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_en", {31'd0, mem_en}, 32'd1);
    chk("post_rst_addr", mem_addr, 32'h200);
    next_cyc();
    if_req = 1'b0; d_req = 1'b0;
    @(negedge CLK);
    chk("post_rst_d_ready", {31'd0, d_ready}, 32'd1);
    chk("post_rst_if_ready", {31'd0, if_ready}, 32'd0);
    next_cyc();

    // single-access vector table, each from a fresh reset
    for (int v = 0; v < 7; v++) begin
      RST = 1'b1;
      next_cyc();
      RST = 1'b0;
      if_req = vt[v].ir; d_req = vt[v].dr; d_we = vt[v].we; d_be = vt[v].be;
      if_addr = vt[v].ia; d_addr = vt[v].da; d_wdata = vt[v].wd;
      if (vt[v].dr && vt[v].we)
        ref_mem[vt[v].da[9:2]] = merge(ref_mem[vt[v].da[9:2]], vt[v].wd, vt[v].be);
      @(negedge CLK);
      chk($sformatf("vec%0d_en", v), {31'd0, mem_en}, {31'd0, vt[v].een});
      chk($sformatf("vec%0d_we", v), {28'd0, mem_we}, {28'd0, vt[v].ewe});
      if (vt[v].een) begin
        chk($sformatf("vec%0d_addr", v), mem_addr, vt[v].eaddr);
        chk($sformatf("vec%0d_wdata", v), mem_wdata, vt[v].ewd);
      end
      next_cyc();
      if_req = 1'b0; d_req = 1'b0;
      @(negedge CLK);
      chk($sformatf("vec%0d_if_ready", v), {31'd0, if_ready}, {31'd0, vt[v].eifr});
      chk($sformatf("vec%0d_d_ready", v), {31'd0, d_ready}, {31'd0, vt[v].edr});
      next_cyc();
    end

    // single fetch
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge CLK);
    chk("fetch_en", {31'd0, mem_en}, 32'd1);
    chk("fetch_we", {28'd0, mem_we}, 32'd0);
    next_cyc();
    if_req = 1'b0;
    @(negedge CLK);
    chk("fetch_ready", {31'd0, if_ready}, 32'd1);
    chk("fetch_rdata", if_rdata, 32'h00500093);
    next_cyc();

    // store then load of the same word
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    ref_mem[64] = merge(ref_mem[64], 32'hDEADBEEF, 4'b0011);
    @(negedge CLK);
    chk("store_we", {28'd0, mem_we}, 32'h3);
    next_cyc();
    d_req = 1'b0;
    @(negedge CLK);
    chk("store_ready", {31'd0, d_ready}, 32'd1);
    next_cyc();
    d_req = 1'b1; d_we = 1'b0;
    @(negedge CLK);
    chk("load_we", {28'd0, mem_we}, 32'd0);
    next_cyc();
    d_req = 1'b0;
    @(negedge CLK);
    chk("load_ready", {31'd0, d_ready}, 32'd1);
    chk("load_rdata", d_rdata, 32'h0000BEEF);
    next_cyc();

    // sustained contention: SL data grants then one forced fetch
    if_req = 1'b1; if_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk($sformatf("cont%0d_en", i), {31'd0, mem_en}, 32'd1);
      chk($sformatf("cont%0d_addr", i), mem_addr, ((i % (SL + 1)) == SL) ? 32'h14 : 32'h40);
      next_cyc();
    end
    if_req = 1'b0; d_req = 1'b0;
    @(negedge CLK);
    next_cyc();

    // back-to-back fetches with incrementing addresses
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        if_req = 1'b1; if_addr = 32'h80 + 32'(4 * k);
      end else begin
        if_req = 1'b0;
      end
      @(negedge CLK);
      if (k < 8) chk($sformatf("b2b%0d_addr", k), mem_addr, 32'h80 + 32'(4 * k));
      if (k > 0) begin
        chk($sformatf("b2b%0d_ready", k), {31'd0, if_ready}, 32'd1);
        chk($sformatf("b2b%0d_rdata", k), if_rdata, ref_mem[32 + k - 1]);
      end
      next_cyc();
    end

    // reset in the completion cycle of a data access
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    @(negedge CLK);
    chk("midrst_grant", {31'd0, mem_en}, 32'd1);
    next_cyc();
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_no_ready", {31'd0, d_ready}, 32'd0);
    next_cyc();
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_after_no_ready", {31'd0, d_ready}, 32'd0);
    chk("midrst_regrant_en", {31'd0, mem_en}, 32'd1);
    chk("midrst_regrant_addr", mem_addr, 32'h44);
    next_cyc();
    d_req = 1'b0;
    @(negedge CLK);
    chk("midrst_ready", {31'd0, d_ready}, 32'd1);
    chk("midrst_rdata", d_rdata, ref_mem[17]);
    next_cyc();
    @(negedge CLK);
    chk("midrst_once", {31'd0, d_ready}, 32'd0);
    next_cyc();

    // randomized run against the request-level model
    RST = 1'b1;
    next_cyc();
    RST = 1'b0;
    ip = 1'b0; dp = 1'b0; st = 0; g = 0; gwe = 1'b0; gdata = 32'h0;
    ia = 32'h0; da = 32'h0; dwd = 32'h0; dwe = 1'b0; dbe = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      pg = g; pdata = gdata; pwe = gwe;
      if (pg == 1) ip = 1'b0;
      if (pg == 2) dp = 1'b0;
      if (!ip && ($urandom_range(0, 99) < 55)) begin
        ip = 1'b1; ia = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!dp && ($urandom_range(0, 99) < 55)) begin
        dp = 1'b1; dwe = 1'($urandom_range(0, 1)); dbe = 4'($urandom);
        da = {22'd0, 8'($urandom_range(0, 255)), 2'b00}; dwd = $urandom;
      end
      if_req = ip; if_addr = ia; d_req = dp; d_we = dwe; d_be = dbe;
      d_addr = da; d_wdata = dwd;
      // data preferred unless the waiting fetch has already seen SL data grants
      if (dp && !(ip && st == SL)) g = 2;
      else if (ip) g = 1;
      else g = 0;
      if (!ip || g == 1) st = 0;
      else if (g == 2) st = (st + 1 > SL) ? SL : st + 1;
      gwe = (g == 2) && dwe;
      if (g == 2) begin
        gdata = ref_mem[da[9:2]];
        if (dwe) ref_mem[da[9:2]] = merge(ref_mem[da[9:2]], dwd, dbe);
      end else if (g == 1) begin
        gdata = ref_mem[ia[9:2]];
      end
      @(negedge CLK);
      chk("rnd_en", {31'd0, mem_en}, (g != 0) ? 32'd1 : 32'd0);
      if (g == 2) begin
        chk("rnd_d_addr", mem_addr, da);
        chk("rnd_d_we", {28'd0, mem_we}, dwe ? {28'd0, dbe} : 32'd0);
        chk("rnd_d_wdata", mem_wdata, dwd);
      end else if (g == 1) begin
        chk("rnd_if_addr", mem_addr, ia);
        chk("rnd_if_we", {28'd0, mem_we}, 32'd0);
        chk("rnd_if_wdata", mem_wdata, 32'd0);
      end else begin
        chk("rnd_idle_we", {28'd0, mem_we}, 32'd0);
      end
      chk("rnd_if_ready", {31'd0, if_ready}, (pg == 1) ? 32'd1 : 32'd0);
      chk("rnd_d_ready", {31'd0, d_ready}, (pg == 2) ? 32'd1 : 32'd0);
      if (pg == 1) chk("rnd_if_rdata", if_rdata, pdata);
      if (pg == 2 && !pwe) chk("rnd_d_rdata", d_rdata, pdata);
      next_cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port, synchronous-read unified memory between the instruction-fetch stage and the load/store stage of the RISC-V core.
- Grants one access per cycle and returns read data or write completion one cycle later.
- Data accesses have priority; a starvation limit guarantees forward fetch progress.
- Instantiated inside top between the core pipeline and the memory block.

Parameters:
ADDR_W, 32, byte address width of both requesters and the memory port
DATA_W, 32, data word width
STARVE_LIMIT, 4, maximum consecutive data grants while a fetch is pending before a fetch grant is forced (range 1..15)

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
if_req  input  1  fetch request, held until if_ready
if_addr  input  ADDR_W  fetch byte address, word aligned
if_ready  output  1  one-cycle pulse, if_rdata valid
if_rdata  output  DATA_W  fetched instruction word
d_req  input  1  data request, held until d_ready
d_we  input  1  1 = store, 0 = load
d_be  input  DATA_W/8  store byte enables
d_addr  input  ADDR_W  data byte address, word aligned
d_wdata  input  DATA_W  store data
d_ready  output  1  one-cycle pulse, access complete and d_rdata valid for loads
d_rdata  output  DATA_W  load data
mem_en  output  1  memory access strobe
mem_we  output  DATA_W/8  byte write enables, all zero for reads
mem_addr  output  ADDR_W  memory byte address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en

Behaviour:
- FSM states:
  - IDLE: nothing outstanding.
  - BUSY_IF: fetch issued last cycle.
  - BUSY_D: data access issued last cycle.
- Arbitration is evaluated every cycle, including the completion cycle of BUSY_*, so back-to-back accesses sustain one per cycle.
- Grant rule:
  - If d_req=1 and not (if_req=1 and starve_cnt==STARVE_LIMIT), grant data.
  - Else if if_req=1, grant fetch.
  - Else no grant; next state is IDLE.
- Grant outputs are combinational in the grant cycle:
  - mem_en=1.
  - mem_addr is the granted address.
  - Data grant: mem_we = d_we ? d_be : 0, mem_wdata=d_wdata.
  - Fetch grant: mem_we=0, mem_wdata=0.
- No grant: mem_en=0, mem_we=0.
- A grant moves the FSM to BUSY_IF or BUSY_D.
- Completion cycle (one cycle after grant): exactly one pulse.
  - BUSY_IF: if_ready=1, if_rdata=mem_rdata.
  - BUSY_D: d_ready=1, d_rdata=mem_rdata (stores: d_rdata don't-care).
- Fixed latency of 1 cycle from grant to ready; throughput of one access per cycle.
- Handshake:
  - A requester must keep req and all request fields stable until its ready pulse.
  - A req still high in the ready cycle is a new request and is arbitrated in that same cycle.
- starve_cnt is 4 bits:
  - Increments on each data grant made while if_req=1, saturating at STARVE_LIMIT.
  - Clears on any fetch grant, and on any cycle with if_req=0.
- Simultaneous if_req and d_req with starve_cnt<STARVE_LIMIT: data wins, and the fetch waits.
- No requests: the block stays in IDLE with all strobes low; no spurious ready pulses.
- Reset, RST=1 at a rising edge:
  - state=IDLE, starve_cnt=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0.
  - While RST=1: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-access: the outstanding access is abandoned, and no ready pulse is produced in the cycle after reset deasserts.
- Addresses pass through unmodified; alignment is the requester's responsibility.

Test Plan:
- Reset: RST=1 for 5 cycles with if_req=1 and d_req=1 -> mem_en=0 and both ready outputs 0 throughout. First cycle after RST=0: mem_en=1 with mem_addr=d_addr.
- Single fetch: if_req=1, if_addr=0x00000010, mem returns 0x00500093 -> mem_en=1 and mem_we=0 in cycle N; if_ready=1 and if_rdata=0x00500093 in cycle N+1.
- Store then load: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEADBEEF -> mem_we=4'b0011 in cycle N and d_ready in N+1. Then a load from 0x100 -> mem_we=0 and d_rdata=the model's 0x0000BEEF.
- Contention: if_req and d_req both held continuously with STARVE_LIMIT=4 -> grant sequence D,D,D,D,IF,D,D,D,D,IF; mem_en=1 every cycle.
- Back-to-back fetches: if_req held for 8 cycles with incrementing addresses -> 8 if_ready pulses on consecutive cycles, each if_rdata matching its address.
- Reset mid-access: assert RST in the cycle after a data grant -> no d_ready pulse. After release, the pending d_req is re-granted and completes once.
